// File: rtl/id_issue_ctrl.sv
// id_issue_ctrl: decode-stage issue controller.
// Holds one decoded instruction, checks it against a per-register scoreboard
// of pending writes and the in-flight count, and offers it to EX when it is
// hazard free. Flush kills the held instruction and all in-flight tracking.
// Optional feature macro: ID_SERIALIZE_EN. When defined, CSR/ERTN-class
// ("serial") instructions wait for an empty pipeline and block the next issue
// until they retire.
module id_issue_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       if_valid,
    output logic       id_allowin,
    input  logic       ex_allowin,
    output logic       id_to_ex_valid,
    input  logic [4:0] reg_j,
    input  logic [4:0] reg_k,
    input  logic [4:0] reg_d,
    input  logic       reg_j_ren,
    input  logic       reg_k_ren,
    input  logic       reg_d_ren,
    input  logic [4:0] dest,
    input  logic       dest_we,
    input  logic       serial,
    input  logic       wb_valid,
    input  logic       wb_we,
    input  logic [4:0] wb_dest,
    input  logic       flush,
    output logic       id_valid,
    output logic       stall,
    output logic [2:0] inflight
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_SERWAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        inflight_q, inflight_d;
    logic [31:0][1:0]  cnt_q, cnt_d;
    logic              serial_s;
    logic              src_busy_s;
    logic              dest_full_s;
    logic              fire_s;
    logic              wb_ok_s;
    logic [31:0]       inc_vec_s;
    logic [31:0]       dec_vec_s;

`ifdef ID_SERIALIZE_EN
    assign serial_s = serial;
`else
    // Serialization compiled out: serial instructions issue like any other.
    logic unused_serial;
    assign unused_serial = serial;
    assign serial_s      = 1'b0;
`endif

    assign id_valid = (state_q == ST_HOLD);
    assign inflight = inflight_q;

    // Hazard detection, issue handshake and retire qualification.
    always_comb begin
        src_busy_s  = (reg_j_ren && (cnt_q[reg_j] != 2'd0)) ||
                      (reg_k_ren && (cnt_q[reg_k] != 2'd0)) ||
                      (reg_d_ren && (cnt_q[reg_d] != 2'd0));
        dest_full_s = dest_we && (cnt_q[dest] == 2'd3);
        stall       = id_valid && (src_busy_s || dest_full_s ||
                                   (inflight_q == 3'd7) ||
                                   (serial_s && (inflight_q != 3'd0)));
        id_to_ex_valid = id_valid && !stall && !flush;
        fire_s      = id_to_ex_valid && ex_allowin;
        // A retire with nothing in flight is spurious and ignored.
        wb_ok_s     = wb_valid && (inflight_q != 3'd0);
    end

    // FSM output: when the ID slot can take a new instruction.
    always_comb begin
        case (state_q)
            ST_EMPTY:   id_allowin = 1'b1;
            // A serial instruction leaving ID must not be followed yet.
            ST_HOLD:    id_allowin = fire_s && !serial_s;
            ST_SERWAIT: id_allowin = 1'b0;
            default:    id_allowin = 1'b0;
        endcase
    end

    // FSM next state; flush overrides any accept or issue this cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (if_valid) state_d = ST_HOLD;
                else          state_d = ST_EMPTY;
            end
            ST_HOLD: begin
                if (fire_s) begin
                    if (serial_s)      state_d = ST_SERWAIT;
                    else if (if_valid) state_d = ST_HOLD;
                    else               state_d = ST_EMPTY;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_SERWAIT: begin
                if (inflight_q == 3'd0) state_d = ST_EMPTY;
                else                    state_d = ST_SERWAIT;
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) state_d = ST_EMPTY;
        else       state_d = state_d;
    end

    // In-flight counter: +1 on issue, -1 on retire, unchanged when both.
    always_comb begin
        if (flush)                   inflight_d = 3'd0;
        else if (fire_s && !wb_ok_s) inflight_d = inflight_q + 3'd1;
        else if (wb_ok_s && !fire_s) inflight_d = inflight_q - 3'd1;
        else                         inflight_d = inflight_q;
    end

    // One-hot register selects for scoreboard increment and decrement.
    always_comb begin
        if (fire_s && dest_we && (dest != 5'd0)) inc_vec_s = 32'd1 << dest;
        else                                     inc_vec_s = 32'd0;
        if (wb_ok_s && wb_we && (wb_dest != 5'd0)) dec_vec_s = 32'd1 << wb_dest;
        else                                       dec_vec_s = 32'd0;
    end

    // Scoreboard update; r0 never counts and zero counters do not underflow.
    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = {64{1'b0}};
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (inc_vec_s[i] && !(dec_vec_s[i] && (cnt_q[i] != 2'd0)))
                    cnt_d[i] = cnt_q[i] + 2'd1;
                else if (dec_vec_s[i] && (cnt_q[i] != 2'd0) && !inc_vec_s[i])
                    cnt_d[i] = cnt_q[i] - 2'd1;
                else
                    cnt_d[i] = cnt_q[i];
            end
        end
        cnt_d[0] = 2'd0;
    end

    // State register; reset wins over flush, issue and accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            inflight_q <= 3'd0;
            cnt_q      <= {64{1'b0}};
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Self-checking bench for id_issue_ctrl: directed scenarios followed by
// random traffic, all compared every cycle against a behavioural model that
// tracks pending writes per register, the in-flight count and slot occupancy.
module tb_id_issue_ctrl;

    logic       clk = 1'b0;
    logic       reset, if_valid, ex_allowin, serial, flush;
    logic [4:0] reg_j, reg_k, reg_d, dest, wb_dest;
    logic       reg_j_ren, reg_k_ren, reg_d_ren, dest_we, wb_valid, wb_we;
    logic       id_allowin, id_to_ex_valid, id_valid, stall;
    logic [2:0] inflight;

`ifdef ID_SERIALIZE_EN
    localparam bit SER_EN = 1'b1;
`else
    localparam bit SER_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    id_issue_ctrl dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .id_allowin(id_allowin),
        .ex_allowin(ex_allowin), .id_to_ex_valid(id_to_ex_valid),
        .reg_j(reg_j), .reg_k(reg_k), .reg_d(reg_d),
        .reg_j_ren(reg_j_ren), .reg_k_ren(reg_k_ren), .reg_d_ren(reg_d_ren),
        .dest(dest), .dest_we(dest_we), .serial(serial),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_dest(wb_dest),
        .flush(flush), .id_valid(id_valid), .stall(stall), .inflight(inflight)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit m_held;       // an instruction sits in ID
    bit m_serw;       // a serial instruction is in flight
    int m_infl;       // issued but not retired
    int m_pend[32];   // outstanding writes per register
    bit e_fire;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_held = 1'b0;
        m_serw = 1'b0;
        m_infl = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
    endtask

    task automatic check_outputs();
        bit hz, ser, e_ex, e_allow;
        ser = SER_EN && serial;
        hz  = 1'b0;
        if (reg_j_ren && reg_j != 5'd0 && m_pend[reg_j] > 0) hz = 1'b1;
        if (reg_k_ren && reg_k != 5'd0 && m_pend[reg_k] > 0) hz = 1'b1;
        if (reg_d_ren && reg_d != 5'd0 && m_pend[reg_d] > 0) hz = 1'b1;
        if (dest_we && dest != 5'd0 && m_pend[dest] >= 3) hz = 1'b1;
        if (m_infl >= 7) hz = 1'b1;
        if (ser && m_infl > 0) hz = 1'b1;
        e_ex    = m_held && !hz && !flush;
        e_fire  = e_ex && ex_allowin;
        e_allow = m_held ? (e_fire && !ser) : !m_serw;
        chk("id_valid", {31'd0, id_valid}, {31'd0, m_held});
        chk("stall", {31'd0, stall}, {31'd0, (m_held && hz)});
        chk("id_to_ex_valid", {31'd0, id_to_ex_valid}, {31'd0, e_ex});
        chk("id_allowin", {31'd0, id_allowin}, {31'd0, e_allow});
        chk("inflight", {29'd0, inflight}, m_infl);
    endtask

    task automatic model_update();
        bit wb_ok, ser, dec_ok;
        int old_infl;
        ser = SER_EN && serial;
        if (reset || flush) begin
            model_clear();
        end else begin
            old_infl = m_infl;
            wb_ok  = wb_valid && (m_infl > 0);
            dec_ok = wb_ok && wb_we && wb_dest != 5'd0 && m_pend[wb_dest] > 0;
            if (e_fire && dest_we && dest != 5'd0) m_pend[dest]++;
            if (dec_ok) m_pend[wb_dest]--;
            m_infl = m_infl + (e_fire ? 1 : 0) - (wb_ok ? 1 : 0);
            if (m_serw) begin
                if (old_infl == 0) m_serw = 1'b0;
            end else if (m_held) begin
                if (e_fire && ser) begin
                    m_held = 1'b0;
                    m_serw = 1'b1;
                end else if (e_fire) begin
                    m_held = if_valid;
                end
            end else begin
                m_held = if_valid;
            end
        end
    endtask

    // One clock: compare mid-cycle, then advance the model at the edge.
    task automatic cyc();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_in(input logic iv, input logic ex, input logic [4:0] j,
                          input logic jr, input logic [4:0] d, input logic dwe,
                          input logic ser, input logic wv, input logic [4:0] wd,
                          input logic fl);
        if_valid = iv;  ex_allowin = ex;
        reg_j = j;      reg_j_ren = jr;
        reg_k = 5'd0;   reg_k_ren = 1'b0;
        reg_d = 5'd0;   reg_d_ren = 1'b0;
        dest = d;       dest_we = dwe;   serial = ser;
        wb_valid = wv;  wb_we = wv;      wb_dest = wd;
        flush = fl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
            cyc();
        end
    endtask

    // Retire n instructions, one per cycle, with the given destination.
    task automatic drain(input int n, input logic [4:0] wd);
        for (int i = 0; i < n; i++) begin
            set_in(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, wd, 1'b0);
            cyc();
        end
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(posedge clk);
        model_clear();
        #1;
        reset = 1'b0;
        #1;
        chk("rst_allowin", {31'd0, id_allowin}, 32'd1);
        chk("rst_inflight", {29'd0, inflight}, 32'd0);
        idle(1);

        // Back-to-back issue: four accepts, four fires, no hazards.
        set_in(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); cyc();
        set_in(1'b1, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0); cyc();
        set_in(1'b1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0); cyc();
        set_in(1'b1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0); cyc();
        set_in(1'b0, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0); cyc();
        chk("b2b_inflight", {29'd0, inflight}, 32'd4);
        chk("b2b_empty", {31'd0, id_valid}, 32'd0);
        for (int r = 1; r <= 4; r++) drain(1, 5'(r));

        // Read-after-write on r5: stall until r5 retires, fire next cycle.
        set_in(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); cyc();
        set_in(1'b1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0); cyc();
        set_in(1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); #1;
        chk("raw_stall", {31'd0, stall}, 32'd1);
        cyc(); cyc();
        set_in(1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0); #1;
        chk("raw_stall_wb", {31'd0, stall}, 32'd1);
        cyc();
        set_in(1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); #1;
        chk("raw_fire", {31'd0, id_to_ex_valid}, 32'd1);
        cyc();
        drain(1, 5'd0);

        // Writes to r0 never create a hazard.
        set_in(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); cyc();
        set_in(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0); cyc();
        set_in(1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); #1;
        chk("r0_nostall", {31'd0, stall}, 32'd0);
        cyc();
        drain(2, 5'd0);

        // Flush while holding, with three in flight and r7 pending.
        set_in(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); cyc();
        set_in(1'b1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0); cyc();
        set_in(1'b1, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0); cyc();
        set_in(1'b1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0); cyc();
        chk("pre_flush_inflight", {29'd0, inflight}, 32'd3);
        set_in(1'b1, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1); cyc();
        chk("flush_id_valid", {31'd0, id_valid}, 32'd0);
        chk("flush_inflight", {29'd0, inflight}, 32'd0);
        set_in(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); #1;
        chk("flush_allowin", {31'd0, id_allowin}, 32'd1);
        cyc();
        set_in(1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); #1;
        chk("flush_r7_clear", {31'd0, stall}, 32'd0);
        cyc();
        set_in(1'b0, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); cyc();
        drain(1, 5'd0);

        // Same-cycle issue and retire on r9 leaves its count unchanged.
        set_in(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); cyc();
        set_in(1'b1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0); cyc();
        set_in(1'b1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0); cyc();
        set_in(1'b0, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); #1;
        chk("r9_still_busy", {31'd0, stall}, 32'd1);
        cyc();
        set_in(1'b0, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0); cyc();
        set_in(1'b0, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); #1;
        chk("r9_released", {31'd0, id_to_ex_valid}, 32'd1);
        cyc();
        drain(1, 5'd0);

`ifdef ID_SERIALIZE_EN
        // Serial instruction waits for an empty pipe, then blocks ID until it retires.
        set_in(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); cyc();
        set_in(1'b1, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0); cyc();
        set_in(1'b1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0); cyc();
        set_in(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0); #1;
        chk("ser_stall", {31'd0, stall}, 32'd1);
        cyc();
        set_in(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0); cyc();
        set_in(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0); cyc();
        set_in(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0); #1;
        chk("ser_fire", {31'd0, id_to_ex_valid}, 32'd1);
        cyc();
        set_in(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); #1;
        chk("serwait_allowin", {31'd0, id_allowin}, 32'd0);
        chk("serwait_id_valid", {31'd0, id_valid}, 32'd0);
        cyc(); cyc();
        set_in(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0); cyc();
        set_in(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); #1;
        chk("serwait_last", {31'd0, id_allowin}, 32'd0);
        cyc();
        chk("serwait_done", {31'd0, id_allowin}, 32'd1);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if_valid   = ($urandom_range(0, 3) != 0);
            ex_allowin = ($urandom_range(0, 3) != 0);
            reg_j = 5'($urandom_range(0, 7)); reg_j_ren = 1'($urandom);
            reg_k = 5'($urandom_range(0, 7)); reg_k_ren = 1'($urandom);
            reg_d = 5'($urandom_range(0, 7)); reg_d_ren = ($urandom_range(0, 3) == 0);
            dest  = 5'($urandom_range(0, 7)); dest_we = ($urandom_range(0, 3) != 0);
            serial   = ($urandom_range(0, 15) == 0);
            wb_valid = ($urandom_range(0, 9) < 4);
            wb_we    = ($urandom_range(0, 3) != 0);
            wb_dest  = 5'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 59) == 0);
            reset    = ($urandom_range(0, 299) == 0);
            cyc();
        end
        reset = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
